fir_dac_spi: RTL and testbench
==============================

Name: fir_dac_spi

Overview:
- Downstream stage of the 8th-order linear-phase FIR: takes the 10-bit filtered sample produced in the 100 kHz domain and ships it to an external 16-bit-frame serial DAC over a 3-wire SPI link (SCLK/CS_n/DIN).
- Runs entirely on the 50 MHz clk_in. The 100 kHz sample clock is treated as a synchronous data signal and edge-detected, so no clock-domain crossing logic is needed.
- One DAC frame is sent per sample; overruns are flagged.

Parameters:
- DATA_W, 10, width of the incoming filtered sample.
- SCLK_DIV, 4, clk_in cycles per SCLK half-period (min 2); 4 gives 6.25 MHz SCLK.
- CTRL_BITS, 4'b0000, 4-bit DAC command header sent first in every frame.
- OFFSET_BIN, 1, 1 = invert sample MSB (two's complement to offset binary) before sending; 0 = send raw.

Ports:
- clk_in  input  1  50 MHz system clock, the only clock.
- reset_p  input  1  asynchronous, active-high reset.
- sample_clk  input  1  100 kHz divided clock that updates the FIR output, sampled as data.
- sample_data  input  DATA_W  FIR output (fir_data).
- dac_sclk  output  1  SPI clock, CPOL=0.
- dac_cs_n  output  1  DAC chip select, active low.
- dac_din  output  1  serial data, MSB first.
- busy  output  1  high from frame accept until the end of GAP.
- frame_done  output  1  one-cycle pulse when CS_n rises at the end of a frame.
- overrun  output  1  sticky; set when a sample edge arrives while busy.

Behaviour:
- Reset (async, immediate): dac_sclk=0, dac_cs_n=1, dac_din=0, busy=0, frame_done=0, overrun=0, FSM=IDLE, edge-detect registers=0, all counters=0.
- Edge detect:
  - sample_clk is registered twice (s1, s2); rise = s1 & ~s2.
  - On the cycle rise is high, sample_data is captured into the shift register. This is 2 clk_in cycles after the sample_clk edge, so FIR data is stable.
- Frame format (16 bits): {CTRL_BITS[3:0], data'[9:0], 2'b00}. data' = sample_data with MSB inverted when OFFSET_BIN=1.
- FSM states: IDLE, SETUP, SHIFT, HOLD, GAP.
- IDLE:
  - On rise: load frame, dac_cs_n=0 and dac_din=frame[15] on the next cycle, busy=1, go to SETUP.
- SETUP:
  - Lasts SCLK_DIV cycles with sclk low (CS_n-to-first-edge setup), then go to SHIFT.
- SHIFT:
  - sclk toggles every SCLK_DIV cycles; 16 rising edges total.
  - DAC samples on the rising edge. dac_din changes only on the falling edge, at the same cycle sclk goes low.
  - bit_cnt counts 0..15. After the 16th falling edge (sclk low), go to HOLD.
- HOLD:
  - SCLK_DIV cycles with cs_n still low and din held, then cs_n=1, frame_done pulse on that cycle, go to GAP.
- GAP:
  - SCLK_DIV cycles with cs_n high (min CS high time), then go to IDLE and busy=0.
- Frame length: SCLK_DIV*(1+32+1+1) cycles = 140 at default, well under the 500-cycle sample period.
- Overrun:
  - A rise while FSM != IDLE drops the new sample and sets overrun, which stays set until reset.
  - The frame in flight is unaffected.
- A rise on the same cycle the FSM returns to IDLE is an overrun (GAP->IDLE transition counts as busy).
- Reset mid-frame: frame is aborted, cs_n high within the async reset, and no frame_done.
- dac_sclk, dac_cs_n and dac_din are driven directly from registers (glitch-free).

Decomposition:
- Shared package (fir_pkg): FRAME_W=16, CTRL_W=4, the FSM state enum, and the default SCLK_DIV.
- One natural sub-module: spi_tick_gen, a SCLK_DIV prescaler producing half-period ticks, cleared when leaving IDLE so SCLK phase is deterministic.
- The rest (edge detect, shift register, FSM) stays in fir_dac_spi.

Test Plan:
- Reset then one sample_clk rise with sample_data=10'h200, OFFSET_BIN=1 -> one frame; DIN bits read on SCLK rising edges = 16'h0000. Check cs_n low to first SCLK rise = 4 cycles; frame_done exactly once, 136 cycles after cs_n falls.
- sample_data=10'h1FF, CTRL_BITS=4'b0011, OFFSET_BIN=0 -> captured word 16'h37FC. Count exactly 16 SCLK rises, and DIN is stable at every rising edge.
- Continuous 100 kHz sample_clk with a ramp 0..1023 -> every frame decodes to the matching ramp value; overrun stays 0; busy low between frames.
- Force a second rise 60 cycles into a frame -> the current frame completes unchanged, the second sample is not sent, and overrun=1 and stays 1 across later normal frames.
- Assert reset_p during SHIFT bit 7 -> cs_n=1, sclk=0 and din=0 immediately without waiting for clk_in; no frame_done. After release, the next rise produces a full clean frame.
- SCLK_DIV=2 -> SCLK = 12.5 MHz with half-period exactly 2 cycles; total frame = 70 cycles.

Source files
------------

// File: rtl/fir_pkg.sv
// -----------------------------------------------------------------------------
// fir_pkg
// Shared definitions for the FIR-to-DAC serial output stage.
//   FRAME_W      : bits per DAC frame (command header + sample + padding)
//   CTRL_W       : width of the DAC command header
//   BIT_CNT_W    : width of the per-frame bit counter (0..FRAME_W-1)
//   SCLK_DIV_DEF : default clk_in cycles per SCLK half-period
//   dac_state_e  : frame sequencer states
// -----------------------------------------------------------------------------
package fir_pkg;

    localparam int FRAME_W      = 16;
    localparam int CTRL_W       = 4;
    localparam int BIT_CNT_W    = 4;
    localparam int SCLK_DIV_DEF = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4
    } dac_state_e;

endpackage

// File: rtl/spi_tick_gen.sv
// -----------------------------------------------------------------------------
// spi_tick_gen
// SCLK_DIV prescaler. tick_o is high for one clk_in cycle at the end of every
// SCLK_DIV-cycle window. While clr_i is high the count is held at zero, so
// the first tick after clr_i drops arrives exactly SCLK_DIV cycles later.
// Ports:
//   clk_in  : system clock
//   reset_p : asynchronous active-high reset
//   clr_i   : hold the prescaler at zero
//   tick_o  : half-period tick
// -----------------------------------------------------------------------------
module spi_tick_gen
    import fir_pkg::*;
#(
    parameter int SCLK_DIV = SCLK_DIV_DEF
) (
    input  logic clk_in,
    input  logic reset_p,
    input  logic clr_i,
    output logic tick_o
);

    localparam int CNT_W = (SCLK_DIV > 2) ? $clog2(SCLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        tick_o = (cnt_q == CNT_LAST);
        if (clr_i || tick_o) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_in or posedge reset_p) begin
        if (reset_p) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fir_dac_spi.sv
// -----------------------------------------------------------------------------
// fir_dac_spi
// Ships each filtered FIR sample to a 16-bit-frame serial DAC over a 3-wire
// SPI link (CPOL=0, data sampled by the DAC on SCLK rising edges, MSB first).
// The 100 kHz sample clock is treated as plain data: it is registered twice
// and its rising edge starts one frame. Frame = {CTRL_BITS, sample', 2'b00}.
// Frame timing in half-periods: SETUP 1, SHIFT 32, HOLD 1, GAP 1.
// Ports:
//   clk_in      : 50 MHz system clock, the only clock
//   reset_p     : asynchronous active-high reset
//   sample_clk  : 100 kHz sample strobe, sampled as data
//   sample_data : filtered sample, captured on the detected rising edge
//   dac_sclk    : SPI clock (idle low)
//   dac_cs_n    : DAC chip select, active low
//   dac_din     : serial data to DAC
//   busy        : frame in progress (accept through end of GAP)
//   frame_done  : one-cycle pulse coincident with dac_cs_n rising
//   overrun     : sticky, a sample edge arrived while busy
// -----------------------------------------------------------------------------
module fir_dac_spi
    import fir_pkg::*;
#(
    parameter int                DATA_W     = 10,
    parameter int                SCLK_DIV   = SCLK_DIV_DEF,
    parameter logic [CTRL_W-1:0] CTRL_BITS  = 4'b0000,
    parameter bit                OFFSET_BIN = 1'b1
) (
    input  logic              clk_in,
    input  logic              reset_p,
    input  logic              sample_clk,
    input  logic [DATA_W-1:0] sample_data,
    output logic              dac_sclk,
    output logic              dac_cs_n,
    output logic              dac_din,
    output logic              busy,
    output logic              frame_done,
    output logic              overrun
);

    localparam int PAD_W = FRAME_W - CTRL_W - DATA_W;
    localparam logic [DATA_W-1:0] MSB_MASK = DATA_W'(1) << (DATA_W - 1);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(FRAME_W - 1);

    // Sample-strobe edge detector
    logic s1_q;
    logic s2_q;
    logic rise;

    // Frame sequencer state
    dac_state_e           state_q, state_d;
    logic [FRAME_W-1:0]   shreg_q, shreg_d;
    logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic                 tail_q, tail_d;     // last bit's falling edge done
    logic                 sclk_q, sclk_d;
    logic                 cs_n_q, cs_n_d;
    logic                 din_q, din_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 ovr_q, ovr_d;

    logic                 tick;
    logic [DATA_W-1:0]    data_x;
    logic [FRAME_W-1:0]   frame_w;

    assign rise    = s1_q & ~s2_q;
    assign data_x  = OFFSET_BIN ? (sample_data ^ MSB_MASK) : sample_data;
    assign frame_w = FRAME_W'({CTRL_BITS, data_x}) << PAD_W;

    // Prescaler held in IDLE so every frame starts with the same SCLK phase.
    spi_tick_gen #(
        .SCLK_DIV (SCLK_DIV)
    ) u_tick (
        .clk_in  (clk_in),
        .reset_p (reset_p),
        .clr_i   (state_q == ST_IDLE),
        .tick_o  (tick)
    );

    always_ff @(posedge clk_in or posedge reset_p) begin
        if (reset_p) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= sample_clk;
            s2_q <= s1_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        tail_d    = tail_q;
        sclk_d    = sclk_q;
        cs_n_d    = cs_n_q;
        din_d     = din_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        // Any edge outside IDLE (including the GAP->IDLE cycle) is dropped.
        ovr_d     = ovr_q | (rise & (state_q != ST_IDLE));

        unique case (state_q)
            ST_IDLE: begin
                if (rise) begin
                    shreg_d   = frame_w;
                    bit_cnt_d = '0;
                    tail_d    = 1'b0;
                    cs_n_d    = 1'b0;
                    din_d     = frame_w[FRAME_W-1];
                    busy_d    = 1'b1;
                    state_d   = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (tick) begin
                    sclk_d  = 1'b1;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (tick) begin
                    if (sclk_q) begin
                        // Falling edge: advance data so it settles a full
                        // half-period before the next rising edge.
                        sclk_d = 1'b0;
                        if (bit_cnt_q == LAST_BIT) begin
                            tail_d = 1'b1;
                        end else begin
                            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                            shreg_d   = shreg_q << 1;
                            din_d     = shreg_q[FRAME_W-2];
                        end
                    end else if (tail_q) begin
                        // Low half-period after the 16th fall has elapsed.
                        state_d = ST_HOLD;
                    end else begin
                        sclk_d = 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (tick) begin
                    cs_n_d  = 1'b1;
                    done_d  = 1'b1;
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                if (tick) begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or posedge reset_p) begin
        if (reset_p) begin
            state_q   <= ST_IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            tail_q    <= 1'b0;
            sclk_q    <= 1'b0;
            cs_n_q    <= 1'b1;
            din_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            tail_q    <= tail_d;
            sclk_q    <= sclk_d;
            cs_n_q    <= cs_n_d;
            din_q     <= din_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ovr_q     <= ovr_d;
        end
    end

    assign dac_sclk   = sclk_q;
    assign dac_cs_n   = cs_n_q;
    assign dac_din    = din_q;
    assign busy       = busy_q;
    assign frame_done = done_q;
    assign overrun    = ovr_q;

endmodule

// File: tb/tb_fir_dac_spi.sv
// -----------------------------------------------------------------------------
// tb_fir_dac_spi
// Two instances: dut_a with defaults (SCLK_DIV=4, CTRL=0000, offset binary)
// and dut_b with SCLK_DIV=2, CTRL=0011, raw data. Stimulus pushes the
// expected DAC word for every accepted sample; a negedge monitor decodes
// each frame from the SPI pins and checks it against the queue at
// frame_done, together with the frame timing.
// -----------------------------------------------------------------------------
module tb_fir_dac_spi;

    logic       clk_in = 1'b0;
    logic       reset_p = 1'b1;

    logic       sc_a = 1'b0, sc_b = 1'b0;
    logic [9:0] sd_a = '0,   sd_b = '0;
    logic       sclk_a, cs_a, din_a, busy_a, fd_a, ovr_a;
    logic       sclk_b, cs_b, din_b, busy_b, fd_b, ovr_b;

    always #10 clk_in = ~clk_in;

    fir_dac_spi dut_a (
        .clk_in      (clk_in),
        .reset_p     (reset_p),
        .sample_clk  (sc_a),
        .sample_data (sd_a),
        .dac_sclk    (sclk_a),
        .dac_cs_n    (cs_a),
        .dac_din     (din_a),
        .busy        (busy_a),
        .frame_done  (fd_a),
        .overrun     (ovr_a)
    );

    fir_dac_spi #(
        .SCLK_DIV   (2),
        .CTRL_BITS  (4'b0011),
        .OFFSET_BIN (1'b0)
    ) dut_b (
        .clk_in      (clk_in),
        .reset_p     (reset_p),
        .sample_clk  (sc_b),
        .sample_data (sd_b),
        .dac_sclk    (sclk_b),
        .dac_cs_n    (cs_b),
        .dac_din     (din_b),
        .busy        (busy_b),
        .frame_done  (fd_b),
        .overrun     (ovr_b)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [15:0] exp_q0[$];
    logic [15:0] exp_q1[$];

    // Monitor state, index 0 = dut_a, 1 = dut_b
    int          fd_cnt[2];
    logic        p_sclk[2];
    logic        p_cs[2];
    logic        p_din[2];
    logic        in_frm[2];
    int          cyc[2];
    int          first_r[2];
    int          rises[2];
    int          last_tog[2];
    int          dviol[2];
    int          hviol[2];
    logic [15:0] word[2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] mk_word(input logic [3:0] c, input bit ob, input logic [9:0] v);
        logic [9:0] x;
        x = ob ? {~v[9], v[8:0]} : v;
        return {c, x, 2'b00};
    endfunction

    function automatic int div_of(input int d);
        return (d == 0) ? 4 : 2;
    endfunction

    task automatic mon_step(input int d, input logic sc, input logic cs, input logic di,
                            input logic fd, input logic bz);
        logic [15:0] e;
        string       nm;
        bit          have;
        nm = (d == 0) ? "a" : "b";
        if (in_frm[d]) cyc[d]++;
        if (p_cs[d] && !cs) begin
            in_frm[d]   = 1'b1;
            cyc[d]      = 0;
            first_r[d]  = -1;
            rises[d]    = 0;
            word[d]     = '0;
            dviol[d]    = 0;
            hviol[d]    = 0;
            last_tog[d] = 0;
        end
        if (in_frm[d] && (sc !== p_sclk[d])) begin
            if (sc) begin
                if (rises[d] == 0) first_r[d] = cyc[d];
                word[d] = {word[d][14:0], di};
                rises[d]++;
                if (di !== p_din[d]) dviol[d]++;
            end
            if (!(sc && rises[d] == 1)) begin
                if (cyc[d] - last_tog[d] != div_of(d)) hviol[d]++;
            end
            last_tog[d] = cyc[d];
        end
        if (fd) begin
            fd_cnt[d]++;
            chk({nm, "_fd_in_frame"}, in_frm[d], 1);
            if (in_frm[d]) begin
                have = 1'b0;
                e    = '0;
                if (d == 0 && exp_q0.size() > 0) begin
                    e = exp_q0.pop_front(); have = 1'b1;
                end else if (d == 1 && exp_q1.size() > 0) begin
                    e = exp_q1.pop_front(); have = 1'b1;
                end
                n_vec++;
                if (!have) begin
                    n_err++;
                    $display("FAIL %s_unexpected_frame: got 0x%0h, want no frame", nm, word[d]);
                end else if (word[d] !== e) begin
                    n_err++;
                    $display("FAIL %s_word: got 0x%0h, want 0x%0h", nm, word[d], e);
                end
                chk({nm, "_rises"}, rises[d], 16);
                chk({nm, "_cs_to_sclk"}, first_r[d], div_of(d));
                chk({nm, "_cs_to_done"}, cyc[d], 34 * div_of(d));
                chk({nm, "_din_stable"}, dviol[d], 0);
                chk({nm, "_half_period"}, hviol[d], 0);
                chk({nm, "_cs_at_done"}, cs, 1);
                chk({nm, "_busy_at_done"}, bz, 1);
            end
            in_frm[d] = 1'b0;
        end
        p_sclk[d] = sc;
        p_cs[d]   = cs;
        p_din[d]  = di;
    endtask

    always @(negedge clk_in) begin
        if (reset_p) begin
            for (int d = 0; d < 2; d++) begin
                in_frm[d] = 1'b0;
                p_sclk[d] = 1'b0;
                p_cs[d]   = 1'b1;
                p_din[d]  = 1'b0;
            end
        end else begin
            mon_step(0, sclk_a, cs_a, din_a, fd_a, busy_a);
            mon_step(1, sclk_b, cs_b, din_b, fd_b, busy_b);
        end
    end

    // Called at a negedge; returns hi+lo negedges later, so back-to-back
    // calls give a rise-to-rise period of exactly hi+lo cycles.
    task automatic pulse(input int d, input logic [9:0] v, input int hi, input int lo);
        if (d == 0) begin sd_a = v; sc_a = 1'b1; end
        else        begin sd_b = v; sc_b = 1'b1; end
        repeat (hi) @(negedge clk_in);
        if (d == 0) sc_a = 1'b0;
        else        sc_b = 1'b0;
        repeat (lo) @(negedge clk_in);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         w;
        int         fdb;
        logic [9:0] v;
        fd_cnt[0] = 0;
        fd_cnt[1] = 0;

        reset_p = 1'b1;
        repeat (3) @(negedge clk_in);
        chk("a_rst_sclk", sclk_a, 0); chk("a_rst_cs_n", cs_a, 1);
        chk("a_rst_din", din_a, 0);   chk("a_rst_busy", busy_a, 0);
        chk("a_rst_done", fd_a, 0);   chk("a_rst_ovr", ovr_a, 0);
        chk("b_rst_sclk", sclk_b, 0); chk("b_rst_cs_n", cs_b, 1);
        chk("b_rst_din", din_b, 0);   chk("b_rst_busy", busy_b, 0);
        chk("b_rst_done", fd_b, 0);   chk("b_rst_ovr", ovr_b, 0);
        reset_p = 1'b0;
        repeat (2) @(negedge clk_in);

        fork
            begin
                exp_q0.push_back(16'h0000);
                pulse(0, 10'h200, 250, 250);
                for (int i = 0; i <= 16; i++) begin
                    v = (i == 16) ? 10'h3FF : 10'(i * 67 + 3);
                    chk("a_busy_idle", busy_a, 0);
                    exp_q0.push_back(mk_word(4'b0000, 1'b1, v));
                    pulse(0, v, 250, 250);
                end
                chk("a_ovr_after_ramp", ovr_a, 0);
                exp_q0.push_back(16'h0694);
                pulse(0, 10'h3A5, 30, 33);
                chk("a_ovr_before_2nd", ovr_a, 0);
                pulse(0, 10'h0F0, 30, 470);
                chk("a_ovr_set", ovr_a, 1);
                exp_q0.push_back(16'h0804);
                pulse(0, 10'h001, 250, 250);
                chk("a_ovr_sticky", ovr_a, 1);
            end
            begin
                exp_q1.push_back(16'h37FC);
                pulse(1, 10'h1FF, 50, 50);
                for (int i = 0; i < 20; i++) begin
                    v = 10'(i * 51 + 7);
                    chk("b_busy_idle", busy_b, 0);
                    exp_q1.push_back(mk_word(4'b0011, 1'b0, v));
                    pulse(1, v, 50, 50);
                end
                chk("b_ovr_after_ramp", ovr_b, 0);
                exp_q1.push_back(16'h3AA8);
                pulse(1, 10'h2AA, 20, 51);
                exp_q1.push_back(16'h3554);
                pulse(1, 10'h155, 20, 50);
                chk("b_ovr_period_71", ovr_b, 0);
                pulse(1, 10'h0F0, 20, 200);
                chk("b_ovr_period_70", ovr_b, 1);
            end
        join

        // Abort a frame with reset while bit 7 is on the wire (sclk and din high).
        sd_a = 10'h2C0;
        sc_a = 1'b1;
        w = 0;
        while (cs_a !== 1'b0 && w < 1000) begin
            @(negedge clk_in);
            w++;
        end
        chk("a_cs_fall_in_time", (w < 1000), 1);
        repeat (62) @(negedge clk_in);
        chk("a_pre_rst_sclk", sclk_a, 1);
        chk("a_pre_rst_din", din_a, 1);
        fdb = fd_cnt[0];
        #2 reset_p = 1'b1;
        #1;
        chk("a_async_cs_n", cs_a, 1);
        chk("a_async_sclk", sclk_a, 0);
        chk("a_async_din", din_a, 0);
        chk("a_async_busy", busy_a, 0);
        chk("a_async_ovr", ovr_a, 0);
        chk("b_async_ovr", ovr_b, 0);
        sc_a = 1'b0;
        repeat (3) @(negedge clk_in);
        reset_p = 1'b0;
        repeat (300) @(negedge clk_in);
        chk("a_no_done_after_abort", fd_cnt[0], fdb);

        exp_q0.push_back(16'h0D54);
        pulse(0, 10'h155, 250, 250);
        chk("a_ovr_after_clean", ovr_a, 0);

        chk("a_queue_empty", exp_q0.size(), 0);
        chk("b_queue_empty", exp_q1.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
